// File: rtl/t03_gpio_pattern_gen.sv
// Run-time configurable GPIO pattern generator: NCH channels, each OFF, CONST,
// SQUARE or PWM, gated onto pin_out/pin_oeb by a registered copy of en.
module t03_gpio_pattern_gen #(
    parameter int unsigned NCH    = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned DUTY_W = 8,
    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_val,
    output logic [NCH-1:0]    pin_out,
    output logic [NCH-1:0]    pin_oeb
);

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_CONST  = 2'd1;
    localparam logic [1:0] MODE_SQUARE = 2'd2;

    // One extra bit so that NCH itself is representable when NCH is a power of two.
    localparam logic [CH_W:0] NCH_L = (CH_W + 1)'(NCH);

    logic [NCH-1:0][1:0]       mode_q, mode_d;
    logic [NCH-1:0][CNT_W-1:0] val_q, val_d;
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]            lvl_q, lvl_d;
    logic                      en_q;
    logic                      cfg_hit_c;

    assign cfg_hit_c = cfg_we && ({1'b0, cfg_ch} < NCH_L);

    // Per-channel pattern update; a config write to a channel overrides its update.
    always_comb begin
        mode_d = mode_q;
        val_d  = val_q;
        cnt_d  = cnt_q;
        lvl_d  = lvl_q;
        for (int i = 0; i < NCH; i++) begin
            if (en) begin
                case (mode_q[i])
                    MODE_OFF: begin
                        cnt_d[i] = '0;
                        lvl_d[i] = 1'b0;
                    end
                    MODE_CONST: begin
                        cnt_d[i] = '0;
                        lvl_d[i] = val_q[i][0];
                    end
                    MODE_SQUARE: begin
                        if (cnt_q[i] == val_q[i]) begin
                            cnt_d[i] = '0;
                            lvl_d[i] = ~lvl_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt_d[i]             = '0;
                        cnt_d[i][DUTY_W-1:0] = cnt_q[i][DUTY_W-1:0] + DUTY_W'(1);
                        lvl_d[i]             = cnt_q[i][DUTY_W-1:0] < val_q[i][DUTY_W-1:0];
                    end
                endcase
            end
            if (cfg_hit_c && (cfg_ch == CH_W'(i))) begin
                mode_d[i] = cfg_mode;
                val_d[i]  = cfg_val;
                cnt_d[i]  = '0;
                lvl_d[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            mode_q <= '0;
            val_q  <= '0;
            cnt_q  <= '0;
            lvl_q  <= '0;
            en_q   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            val_q  <= val_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            en_q   <= en;
        end
    end

    // Pins are a bare gate of flops so they stay glitch-free at the pad.
    assign pin_out = lvl_q & {NCH{en_q}};
    assign pin_oeb = {NCH{~en_q}};

endmodule
